// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the MEM/WB pipeline stage.
// Writeback source select and stage FSM states.
package mem_wb_stage_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_MEM  = 2'b01,
        WB_SEL_LINK = 2'b10,
        WB_SEL_RSVD = 2'b11
    } wb_sel_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } wb_state_e;

endpackage

// File: rtl/mem_wb_stage_wb_mux.sv
// Writeback source selector.
// Pure 4:1 combinational mux.
module wb_mux #(
    parameter int DATA_W = 16
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] mem_i,
    input  logic [DATA_W-1:0] link_i,
    input  logic [DATA_W-1:0] rsvd_i,
    output logic [DATA_W-1:0] data_o
);

    import mem_wb_stage_pkg::*;

    // select the value written back to the register file
    always_comb begin
        data_o = rsvd_i;
        unique case (sel)
            WB_SEL_ALU:  data_o = alu_i;
            WB_SEL_MEM:  data_o = mem_i;
            WB_SEL_LINK: data_o = link_i;
            default:     data_o = rsvd_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, writeback drive,
// halt FSM and retired-instruction counter.
module mem_wb_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              reg_write,
    input  logic [1:0]        wb_sel,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              is_halt,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] link_addr,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              halted,
    output logic [15:0]       retired_count
);

    import mem_wb_stage_pkg::*;

    logic              valid_q, valid_d;
    logic              reg_write_q, reg_write_d;
    logic [1:0]        wb_sel_q, wb_sel_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              halt_q, halt_d;
    logic [DATA_W-1:0] mem_q, mem_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] link_q, link_d;
    wb_state_e         state_q, state_d;
    logic [CNT_W-1:0]  retired_count_q, retired_count_d;
    logic              retire;

    // pipeline register next value: flush beats stall, halt kills valid
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        wb_sel_d    = wb_sel_q;
        rd_d        = rd_q;
        halt_d      = halt_q;
        mem_d       = mem_q;
        alu_d       = alu_q;
        link_d      = link_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d     = in_valid;
            reg_write_d = reg_write;
            wb_sel_d    = wb_sel;
            rd_d        = rd_addr;
            halt_d      = is_halt;
            mem_d       = read_data;
            alu_d       = mem_alu_result;
            link_d      = link_addr;
        end
        if (state_q == ST_HALTED) begin
            valid_d = 1'b0;
        end
    end

    // pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            wb_sel_q    <= 2'b00;
            rd_q        <= '0;
            halt_q      <= 1'b0;
            mem_q       <= '0;
            alu_q       <= '0;
            link_q      <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            wb_sel_q    <= wb_sel_d;
            rd_q        <= rd_d;
            halt_q      <= halt_d;
            mem_q       <= mem_d;
            alu_q       <= alu_d;
            link_q      <= link_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a live HALT leaving the stage stops the core
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && valid_q && halt_q && !stall) begin
            state_d = ST_HALTED;
        end
    end

    // FSM outputs
    always_comb begin
        halted = (state_q == ST_HALTED);
    end

    // an entry retires when it leaves the register, even if flushed behind
    always_comb begin
        retire          = (state_q == ST_RUN) && valid_q && (!stall || flush);
        retired_count_d = retired_count_q;
        if (retire) begin
            retired_count_d = retired_count_q + 16'd1;
        end
    end

    // retired-instruction counter, wraps silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_count_q <= '0;
        end else begin
            retired_count_q <= retired_count_d;
        end
    end

    // writeback enable and address straight off the register
    always_comb begin
        wb_en = valid_q && reg_write_q && (rd_q != '0) &&
                !halt_q && !halted;
        wb_addr       = rd_q;
        retired_count = retired_count_q;
    end

    wb_mux #(
        .DATA_W (DATA_W)
    ) u_wb_mux (
        .sel    (wb_sel_q),
        .alu_i  (alu_q),
        .mem_i  (mem_q),
        .link_i (link_q),
        .rsvd_i ({DATA_W{1'b0}}),
        .data_o (wb_data)
    );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage.
// Directed scenarios plus random traffic vs a behavioural model.
module tb_mem_wb_stage;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall, flush, in_valid, reg_write, is_halt;
    logic [1:0]    wb_sel;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] read_data, mem_alu_result, link_addr;
    logic          wb_en, halted;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [15:0]   retired_count;

    int n_tests = 0;
    int n_fail  = 0;

    mem_wb_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .in_valid       (in_valid),
        .reg_write      (reg_write),
        .wb_sel         (wb_sel),
        .rd_addr        (rd_addr),
        .is_halt        (is_halt),
        .read_data      (read_data),
        .mem_alu_result (mem_alu_result),
        .link_addr      (link_addr),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .halted         (halted),
        .retired_count  (retired_count)
    );

    always #5 clk = ~clk;

    // behavioural model: one slot in flight, a halted flag, a count
    bit          m_valid, m_rw, m_halt, m_halted;
    bit [1:0]    m_sel;
    bit [AW-1:0] m_rd;
    bit [DW-1:0] m_mem, m_alu, m_link;
    int          m_count;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_en();
        return m_valid && m_rw && (m_rd != 0) && !m_halt && !m_halted;
    endfunction

    function automatic bit [DW-1:0] m_data();
        case (m_sel)
            2'd0:    return m_alu;
            2'd1:    return m_mem;
            2'd2:    return m_link;
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_halt = 0; m_halted = 0;
        m_sel = 0; m_rd = 0; m_mem = 0; m_alu = 0; m_link = 0;
        m_count = 0;
    endtask

    task automatic model_edge();
        bit was_halted;
        was_halted = m_halted;
        if (!m_halted && m_valid && (!stall || flush))
            m_count = (m_count + 1) % 65536;
        if (!m_halted && m_valid && m_halt && !stall)
            m_halted = 1;
        if (flush) begin
            m_valid = 0;
        end else if (!stall) begin
            m_valid = in_valid; m_rw = reg_write; m_sel = wb_sel;
            m_rd = rd_addr; m_halt = is_halt; m_mem = read_data;
            m_alu = mem_alu_result; m_link = link_addr;
        end
        if (was_halted) m_valid = 0;
    endtask

    task automatic check_all(input string p);
        chk({p, "_en"}, wb_en, m_en());
        chk({p, "_halted"}, halted, m_halted);
        chk({p, "_count"}, retired_count, m_count);
        if (m_valid) begin
            chk({p, "_addr"}, wb_addr, m_rd);
            chk({p, "_data"}, wb_data, m_data());
        end
    endtask

    task automatic step(input string p);
        @(posedge clk);
        model_edge();
        #1;
        check_all(p);
    endtask

    task automatic drive(input bit v, input bit rw, input bit [1:0] sel,
                         input bit [AW-1:0] rd, input bit h,
                         input bit [DW-1:0] alu, input bit [DW-1:0] mem,
                         input bit [DW-1:0] lnk);
        in_valid = v; reg_write = rw; wb_sel = sel; rd_addr = rd;
        is_halt = h; mem_alu_result = alu; read_data = mem;
        link_addr = lnk;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        stall = 0; flush = 0;
    endtask

    task automatic do_reset(input bit chk_out);
        rst_n = 1'b0;
        model_reset();
        #1;
        if (chk_out) begin
            chk("rst_en", wb_en, 0);
            chk("rst_addr", wb_addr, 0);
            chk("rst_data", wb_data, 0);
            chk("rst_halted", halted, 0);
            chk("rst_count", retired_count, 0);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_inputs();
        stall = ($urandom_range(0, 3) == 0);
        flush = ($urandom_range(0, 7) == 0);
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 1),
              2'($urandom_range(0, 3)), AW'($urandom_range(0, 7)),
              $urandom_range(0, 39) == 0, 16'($urandom),
              16'($urandom), 16'($urandom));
    endtask

    initial begin
        int c0;
        rst_n = 1'b1;
        idle();
        #2;
        do_reset(1);

        // load from memory
        drive(1, 1, 2'b01, 3, 0, 16'h1111, 16'hBEEF, 16'h2222);
        step("load");
        chk("load_en_c", wb_en, 1);
        chk("load_addr_c", wb_addr, 3);
        chk("load_data_c", wb_data, 16'hBEEF);
        idle();
        step("load2");
        chk("load_count_c", retired_count, 1);

        // r0 destination still retires
        drive(1, 1, 2'b00, 0, 0, 16'h1234, 0, 0);
        step("r0");
        chk("r0_en_c", wb_en, 0);
        idle();
        step("r0b");
        chk("r0_count_c", retired_count, 2);

        // stall holds, stall+flush retires once
        drive(1, 1, 2'b00, 2, 0, 16'h0042, 0, 0);
        step("st");
        c0 = m_count;
        drive(1, 1, 2'b00, 6, 0, 16'h0099, 0, 0);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk("stall_data_c", wb_data, 16'h0042);
            chk("stall_count_c", retired_count, c0);
        end
        flush = 1;
        step("sflush");
        chk("sflush_en_c", wb_en, 0);
        chk("sflush_count_c", retired_count, c0 + 1);
        idle();
        step("sflush2");

        // halt
        drive(1, 1, 2'b00, 5, 1, 16'h5555, 0, 0);
        step("halt");
        chk("halt_en_c", wb_en, 0);
        chk("halt_h0_c", halted, 0);
        c0 = m_count;
        idle();
        step("halt2");
        chk("halt_h1_c", halted, 1);
        chk("halt_count_c", retired_count, c0 + 1);
        drive(1, 1, 2'b00, 4, 0, 16'h7777, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("halted");
            chk("halted_en_c", wb_en, 0);
            chk("halted_count_c", retired_count, c0 + 1);
        end

        // async reset while writing back
        idle();
        do_reset(0);
        drive(1, 1, 2'b00, 1, 0, 16'hABCD, 0, 0);
        for (int i = 0; i < 3; i++) step("pre_ar");
        chk("pre_ar_en_c", wb_en, 1);
        chk("pre_ar_count_c", retired_count, 2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_en_c", wb_en, 0);
        chk("ar_count_c", retired_count, 0);
        chk("ar_data_c", wb_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // wrap: back-to-back retires with random payloads
        while (m_count != 65535) begin
            drive(1, $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                  AW'($urandom_range(0, 7)), 0, 16'($urandom),
                  16'($urandom), 16'($urandom));
            step("wrapfill");
        end
        chk("wrap_ffff_c", retired_count, 16'hFFFF);
        step("wrap");
        chk("wrap_zero_c", retired_count, 16'h0000);
        idle();
        step("wrap2");

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ((m_halted && $urandom_range(0, 7) == 0) ||
                $urandom_range(0, 299) == 0) begin
                if ($urandom_range(0, 1) == 1) stall = 1;
                do_reset(1);
            end
            rand_inputs();
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter: DATA_W, 16, datapath width.
REQ-002 Parameter: REG_AW, 3, register-address width (8 registers, r0 reads as zero).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  hold pipeline register contents.
REQ-006 flush  input  1  invalidate pipeline register.
REQ-007 in_valid  input  1  MEM-stage instruction is valid.
REQ-008 reg_write  input  1  instruction writes the register file.
REQ-009 wb_sel  input  2  writeback source: 00 ALU, 01 memory, 10 link, 11 reserved.
REQ-010 rd_addr  input  REG_AW  destination register.
REQ-011 is_halt  input  1  instruction is HALT.
REQ-012 read_data  input  DATA_W  data-memory read result, valid in the same cycle as the MEM-stage control.
REQ-013 mem_alu_result  input  DATA_W  ALU result passed through MEM.
REQ-014 link_addr  input  DATA_W  return address (PC+2) for link writes.
REQ-015 wb_en  output  1  register-file write enable.
REQ-016 wb_addr  output  REG_AW  register-file write address.
REQ-017 wb_data  output  DATA_W  register-file write data; also the forwarding source for EX.
REQ-018 halted  output  1  core halted (sticky).
REQ-019 retired_count  output  16  count of retired instructions.

Function
REQ-020 Pipeline register fields: valid_q, reg_write_q, wb_sel_q, rd_q, halt_q, mem_q, alu_q, link_q.
REQ-021 Each rising edge: if flush=1, valid_q<=0 and the other fields are don't-care; else if stall=1, all fields hold; else all fields capture their inputs.
REQ-022 flush SHALL take priority over stall when both are 1.
REQ-023 Latency: exactly one cycle from capture to wb_en/wb_data.
REQ-024 wb_data mux on wb_sel_q: 00 alu_q, 01 mem_q, 10 link_q, 11 16'h0000.
REQ-025 wb_en = valid_q & reg_write_q & (rd_q != 0) & ~halt_q & ~halted.
REQ-026 wb_addr = rd_q; wb_data is combinational from the register outputs.
REQ-027 While stalled, wb_en and wb_data hold their values and the rewrite is idempotent.
REQ-028 FSM states: RUN and HALTED. RUN->HALTED on the rising edge where valid_q=1, halt_q=1 and stall=0. HALTED exits only on reset. halted=1 in HALTED.
REQ-029 In HALTED, valid_q is forced to 0 on every edge regardless of in_valid, and retired_count freezes.
REQ-030 retired_count increments by 1 on each edge in RUN where valid_q=1 and (stall=0 or flush=1); the HALT instruction itself counts.
REQ-031 retired_count wraps 16'hFFFF -> 16'h0000 with no flag.
REQ-032 A flush that coincides with a retiring valid_q entry still counts that entry; flush invalidates only the incoming instruction.

Reset
REQ-033 On rst_n=0, immediately: valid_q=0, FSM=RUN, retired_count=0, all datapath fields=0; as a result wb_en=0, wb_addr=0, wb_data=0, halted=0.
REQ-034 Reset asserted mid-stall or while HALTED overrides all other inputs; operation resumes on the first edge after deassertion.

Structure
REQ-035 WB_SEL_ALU/MEM/LINK/RSVD encodings and the RUN/HALTED state encodings belong in the shared defines file.
REQ-036 The writeback source mux is a sub-module, wb_mux (combinational, 4:1, DATA_W wide).

Verification
REQ-037 Load: in_valid=1, reg_write=1, wb_sel=01, rd=3, read_data=16'hBEEF -> next cycle wb_en=1, wb_addr=3, wb_data=16'hBEEF, retired_count=1 after the following edge.
REQ-038 r0 target: reg_write=1, rd=0, alu=16'h1234 -> wb_en=0; the instruction still counts as retired.
REQ-039 Stall+flush: with entry ALU 16'h0042 held, assert stall for 3 cycles -> wb_data stays 16'h0042 and the count is unchanged; then assert stall=1 and flush=1 together -> valid_q=0 next cycle and the count increments once.
REQ-040 Halt: HALT with reg_write=1, rd=5 -> wb_en=0; halted=1 one edge later; later in_valid instructions produce no wb_en and no count change.
REQ-041 Wrap: preload the count to 16'hFFFF via 65535 retires (or force), retire one more -> 16'h0000.
REQ-042 Async reset: drop rst_n between edges while wb_en=1 -> wb_en=0 and retired_count=0 before the next edge.
